// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   - state encoding for the frame parser FSM
//   - default frame sync marker
//   - width of the LEN (word count) field
package imem_loader_pkg;

  localparam int LEN_WIDTH = 16;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN0 = 3'd1;
  localparam logic [2:0] ST_LEN1 = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CSUM = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;
  localparam logic [2:0] ST_ERR  = 3'd6;

  // True while a frame is being received (after the sync byte, before the verdict).
  function automatic logic is_busy_state(input logic [2:0] st);
    return (st == ST_LEN0) || (st == ST_LEN1) || (st == ST_DATA) || (st == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_byte_word_assembler.sv
// Little-endian byte-to-word assembler, shared by the data and checksum phases.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   clear       - synchronous restart of the byte counter and shift register
//   byte_in     - incoming byte, byte_valid qualifies it
//   word        - assembled word including the byte currently presented
//   word_valid  - high in the cycle the 4th byte of a word is presented
module byte_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_r;
  logic [31:0] shift_r;

  // New bytes enter at the top and shift down, so after four bytes byte k
  // sits at bits 8k+7:8k.
  assign word       = {byte_in, shift_r[31:8]};
  assign word_valid = byte_valid && (cnt_r == 2'd3);

  // Byte counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= 2'd0;
      shift_r <= 32'd0;
    end else if (clear) begin
      cnt_r   <= 2'd0;
      shift_r <= 32'd0;
    end else if (byte_valid) begin
      cnt_r   <= cnt_r + 2'd1;
      shift_r <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed byte stream
// (SYNC, LEN_LO, LEN_HI, LEN little-endian words, 32-bit checksum) and writes
// the words into the IROM write port, holding the CPU in reset until the
// checksum has been verified.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   s_data, s_valid, s_ready   - byte stream (transfer on s_valid && s_ready)
//   start                      - re-arm pulse, honoured only in DONE/ERR
//   mem_we, mem_addr, mem_wdata- IROM write port (one-cycle strobe)
//   cpu_rst_n                  - CPU reset, released only after a verified load
//   busy, done, err            - loader status
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 14,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  start,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // One extra bit so a full-depth load counts to 2**ADDR_WIDTH without wrapping.
  localparam int CNT_W = ADDR_WIDTH + 1;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [CNT_W-1:0]       word_idx_r;
  logic [LEN_WIDTH-1:0]   len_r;
  logic [7:0]             len_lo_r;
  logic [31:0]            csum_r;

  logic                   xfer_s;
  logic                   rearm_s;
  logic [LEN_WIDTH-1:0]   len_full_s;
  logic                   oversize_s;
  logic                   last_word_s;
  logic                   asm_valid_s;
  logic                   asm_clear_s;
  logic [31:0]            asm_word_s;
  logic                   asm_word_valid_s;

  assign xfer_s      = s_valid && s_ready;
  assign rearm_s     = ((state_r == ST_DONE) || (state_r == ST_ERR)) && start;
  assign len_full_s  = {s_data, len_lo_r};
  assign oversize_s  = 32'(len_full_s) > (32'd1 << ADDR_WIDTH);
  assign last_word_s = (32'(word_idx_r) + 32'd1) == 32'(len_r);
  assign asm_valid_s = xfer_s && ((state_r == ST_DATA) || (state_r == ST_CSUM));
  assign asm_clear_s = rearm_s || ((state_r == ST_IDLE) && xfer_s);

  byte_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear_s),
    .byte_in    (s_data),
    .byte_valid (asm_valid_s),
    .word       (asm_word_s),
    .word_valid (asm_word_valid_s)
  );

  // Next-state logic of the frame parser.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s && (s_data == SYNC_BYTE)) state_next_s = ST_LEN0;
        else                                 state_next_s = ST_IDLE;
      end
      ST_LEN0: begin
        if (xfer_s) state_next_s = ST_LEN1;
        else        state_next_s = ST_LEN0;
      end
      ST_LEN1: begin
        if (!xfer_s)                          state_next_s = ST_LEN1;
        else if (oversize_s)                  state_next_s = ST_ERR;
        else if (len_full_s == 16'd0)         state_next_s = ST_CSUM;
        else                                  state_next_s = ST_DATA;
      end
      ST_DATA: begin
        if (asm_word_valid_s && last_word_s) state_next_s = ST_CSUM;
        else                                 state_next_s = ST_DATA;
      end
      ST_CSUM: begin
        if (!asm_word_valid_s)               state_next_s = ST_CSUM;
        else if (asm_word_s == csum_r)       state_next_s = ST_DONE;
        else                                 state_next_s = ST_ERR;
      end
      ST_DONE, ST_ERR: begin
        if (start) state_next_s = ST_IDLE;
        else       state_next_s = state_r;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, counters, write port and status outputs. Status is registered from
  // the next state so it changes in the same cycle the state does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      word_idx_r <= '0;
      len_r      <= '0;
      len_lo_r   <= 8'd0;
      csum_r     <= 32'd0;
      s_ready    <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      cpu_rst_n  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      s_ready   <= !((state_next_s == ST_DONE) || (state_next_s == ST_ERR));
      busy      <= is_busy_state(state_next_s);
      done      <= (state_next_s == ST_DONE);
      err       <= (state_next_s == ST_ERR);
      cpu_rst_n <= (state_next_s == ST_DONE);
      mem_we    <= (state_r == ST_DATA) && asm_word_valid_s;

      if (rearm_s || ((state_r == ST_IDLE) && (state_next_s == ST_LEN0))) begin
        word_idx_r <= '0;
        csum_r     <= 32'd0;
        len_r      <= '0;
        mem_addr   <= '0;
        mem_wdata  <= 32'd0;
      end else if ((state_r == ST_DATA) && asm_word_valid_s) begin
        mem_addr   <= word_idx_r[ADDR_WIDTH-1:0];
        mem_wdata  <= asm_word_s;
        word_idx_r <= word_idx_r + {{(CNT_W-1){1'b0}}, 1'b1};
        csum_r     <= csum_r + asm_word_s;
      end else if ((state_r == ST_LEN1) && xfer_s) begin
        len_r <= len_full_s;
      end else begin
        len_r <= len_r;
      end

      if ((state_r == ST_LEN0) && xfer_s) len_lo_r <= s_data;
      else                                len_lo_r <= len_lo_r;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          start;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst_n;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .start(start), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  tx_q[$];
  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_done;
  bit          exp_err;

  typedef struct {
    logic [191:0] frame;   // first byte in the most significant used position
    int           nbytes;
    int           exp_nw;
    logic [31:0]  w0;
    logic [31:0]  w1;
    bit           e_done;
    bit           e_err;
  } vec_t;

  vec_t vecs[5];

  // Write-port monitor: one entry per cycle mem_we is high.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      cap_addr.push_back(32'(mem_addr));
      cap_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: parse tx_q from the frame rules.
  task automatic run_model();
    int i = 0;
    int len;
    int p;
    logic [31:0] sum = 32'd0;
    logic [31:0] w;
    logic [31:0] cs;
    exp_addr.delete();
    exp_data.delete();
    while (i < tx_q.size() && tx_q[i] != 8'hA5) i++;
    len = int'(tx_q[i+1]) + 256 * int'(tx_q[i+2]);
    p = i + 3;
    if (len > DEPTH) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    for (int k = 0; k < len; k++) begin
      w = {tx_q[p+3], tx_q[p+2], tx_q[p+1], tx_q[p]};
      exp_addr.push_back(32'(k));
      exp_data.push_back(w);
      sum += w;
      p += 4;
    end
    cs = {tx_q[p+3], tx_q[p+2], tx_q[p+1], tx_q[p]};
    exp_done = (cs == sum);
    exp_err  = !exp_done;
  endtask

  task automatic send_tx(input bit gaps, input bit starts);
    for (int i = 0; i < tx_q.size(); i++) begin
      int guard = 0;
      bit sent = 1'b0;
      while (!sent) begin
        @(negedge clk);
        start = starts && ($urandom_range(7) == 0);
        if (gaps && $urandom_range(2) == 0) begin
          s_valid = 1'b0;
        end else begin
          s_valid = 1'b1;
          s_data  = tx_q[i];
          if (s_ready) sent = 1'b1;
        end
        guard++;
        if (!sent && guard > 64) begin
          n_tests++;
          n_fail++;
          $display("FAIL stall: byte %0d not accepted, s_ready %b expected 1", i, s_ready);
          @(negedge clk);
          s_valid = 1'b0;
          start = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    start   = 1'b0;
  endtask

  task automatic rearm();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cap_addr.delete();
    cap_data.delete();
  endtask

  task automatic check_status(input string tag, input bit e_done, input bit e_err);
    check({tag, ".done"}, 32'(done), 32'(e_done));
    check({tag, ".err"}, 32'(err), 32'(e_err));
    check({tag, ".cpu_rst_n"}, 32'(cpu_rst_n), 32'(e_done));
    check({tag, ".s_ready"}, 32'(s_ready), 32'(!(e_done || e_err)));
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_writes(input string tag);
    check({tag, ".nwrites"}, 32'(cap_data.size()), 32'(exp_data.size()));
    for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
      check({tag, ".addr"}, cap_addr[i], exp_addr[i]);
      check({tag, ".data"}, cap_data[i], exp_data[i]);
    end
  endtask

  task automatic build_random(input int len, input bit good, input int garbage);
    logic [7:0]  b;
    logic [15:0] len16 = 16'(len);
    logic [31:0] w;
    logic [31:0] sum = 32'd0;
    tx_q.delete();
    for (int g = 0; g < garbage; g++) begin
      b = 8'($urandom_range(255));
      if (b == 8'hA5) b = 8'h00;
      tx_q.push_back(b);
    end
    tx_q.push_back(8'hA5);
    tx_q.push_back(len16[7:0]);
    tx_q.push_back(len16[15:8]);
    if (len > DEPTH) return;
    for (int k = 0; k < len; k++) begin
      w = $urandom;
      for (int j = 0; j < 4; j++) tx_q.push_back(w[8*j +: 8]);
      sum += w;
    end
    if (!good) sum ^= (32'd1 << $urandom_range(31));
    for (int j = 0; j < 4; j++) tx_q.push_back(sum[8*j +: 8]);
  endtask

  initial begin
    vecs[0] = '{frame: 192'({8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                             8'h93, 8'h00, 8'h10, 8'h00, 8'hA6, 8'h00, 8'h10, 8'h00}),
                nbytes: 15, exp_nw: 2, w0: 32'h00000013, w1: 32'h00100093, e_done: 1'b1, e_err: 1'b0};
    vecs[1] = '{frame: 192'({8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                             8'h93, 8'h00, 8'h10, 8'h00, 8'hA7, 8'h00, 8'h10, 8'h00}),
                nbytes: 15, exp_nw: 2, w0: 32'h00000013, w1: 32'h00100093, e_done: 1'b0, e_err: 1'b1};
    vecs[2] = '{frame: 192'({8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h21, 8'h07,
                             8'h00, 8'h0D, 8'h21, 8'h07, 8'h00, 8'h0D}),
                nbytes: 14, exp_nw: 1, w0: 32'h0D000721, w1: 32'h0, e_done: 1'b1, e_err: 1'b0};
    vecs[3] = '{frame: 192'({8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}),
                nbytes: 7, exp_nw: 0, w0: 32'h0, w1: 32'h0, e_done: 1'b1, e_err: 1'b0};
    vecs[4] = '{frame: 192'({8'hA5, 8'h11, 8'h00}),
                nbytes: 3, exp_nw: 0, w0: 32'h0, w1: 32'h0, e_done: 1'b0, e_err: 1'b1};

    rst = 1'b1; s_data = 8'h00; s_valid = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.s_ready", 32'(s_ready), 32'd1);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_addr", 32'(mem_addr), 32'd0);
    check("rst.mem_wdata", mem_wdata, 32'd0);
    check_status("rst", 1'b0, 1'b0);

    // Directed table from the frame examples.
    for (int v = 0; v < 5; v++) begin
      rearm();
      tx_q.delete();
      exp_addr.delete();
      exp_data.delete();
      for (int i = 0; i < vecs[v].nbytes; i++)
        tx_q.push_back(vecs[v].frame[8*(vecs[v].nbytes-1-i) +: 8]);
      if (vecs[v].exp_nw > 0) begin exp_addr.push_back(32'd0); exp_data.push_back(vecs[v].w0); end
      if (vecs[v].exp_nw > 1) begin exp_addr.push_back(32'd1); exp_data.push_back(vecs[v].w1); end
      send_tx(1'b0, 1'b0);
      check_status($sformatf("vec%0d", v), vecs[v].e_done, vecs[v].e_err);
      check_writes($sformatf("vec%0d", v));
    end

    // Nominal frame with random gaps and mid-frame start pulses.
    rearm();
    tx_q.delete();
    for (int i = 0; i < vecs[0].nbytes; i++)
      tx_q.push_back(vecs[0].frame[8*(vecs[0].nbytes-1-i) +: 8]);
    run_model();
    send_tx(1'b1, 1'b1);
    check_status("gaps", exp_done, exp_err);
    check_writes("gaps");

    // Full-depth load: addresses run to DEPTH-1 without wrapping.
    rearm();
    build_random(DEPTH, 1'b1, 0);
    run_model();
    send_tx(1'b0, 1'b0);
    check_status("full", exp_done, exp_err);
    check_writes("full");

    // Randomized frames against the model.
    for (int t = 0; t < 30; t++) begin
      int len = ($urandom_range(7) == 0) ? int'($urandom_range(DEPTH + 1, 300)) : int'($urandom_range(0, DEPTH));
      rearm();
      build_random(len, $urandom_range(4) != 0, int'($urandom_range(0, 3)));
      run_model();
      send_tx(1'b1, 1'b1);
      check_status($sformatf("rnd%0d", t), exp_done, exp_err);
      check_writes($sformatf("rnd%0d", t));
    end

    // Reset after 6 data bytes, then reload and re-arm.
    rearm();
    tx_q.delete();
    for (int i = 0; i < 9; i++)
      tx_q.push_back(vecs[0].frame[8*(vecs[0].nbytes-1-i) +: 8]);
    send_tx(1'b0, 1'b0);
    check("mid.busy", 32'(busy), 32'd1);
    check("mid.nwrites", 32'(cap_data.size()), 32'd1);
    cap_addr.delete();
    cap_data.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst.s_ready", 32'(s_ready), 32'd1);
    check("mrst.mem_we", 32'(mem_we), 32'd0);
    check("mrst.mem_addr", 32'(mem_addr), 32'd0);
    check("mrst.mem_wdata", mem_wdata, 32'd0);
    check_status("mrst", 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("mrst.nwrites", 32'(cap_data.size()), 32'd0);
    tx_q.delete();
    for (int i = 0; i < vecs[0].nbytes; i++)
      tx_q.push_back(vecs[0].frame[8*(vecs[0].nbytes-1-i) +: 8]);
    run_model();
    send_tx(1'b0, 1'b0);
    check_status("reload", exp_done, exp_err);
    check_writes("reload");
    rearm();
    check("rearm.cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rearm.done", 32'(done), 32'd0);
    check("rearm.s_ready", 32'(s_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
